hyperbus_txn_ctrl: RTL and testbench



---
 rtl/hyperbus_pkg.sv | 37 +++
 rtl/hyperbus_txn_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_hyperbus_txn_ctrl.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hyperbus_pkg.sv
// Shared types and helpers for the HyperBus transaction sequencer.
package hyperbus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CS_SETUP,
    ST_CMD,
    ST_LATENCY,
    ST_WDATA,
    ST_RDATA,
    ST_CS_HOLD,
    ST_RECOVERY
  } state_e;

  typedef struct packed {
    logic        rw;
    logic        as;
    logic        burst;
    logic [28:0] addr_hi;
    logic [12:0] rsvd;
    logic [2:0]  addr_lo;
  } ca_t;

  localparam int unsigned DEFAULT_RWR = 4;

  function automatic ca_t ca_pack(input logic write, input logic [31:0] addr);
    ca_t ca;
    ca.rw      = ~write;
    ca.as      = 1'b0;
    ca.burst   = 1'b1;
    ca.addr_hi = addr[31:3];
    ca.rsvd    = '0;
    ca.addr_lo = addr[2:0];
    return ca;
  endfunction

endpackage

// File: rtl/hyperbus_txn_ctrl.sv
// HyperBus transaction sequencer: one burst at a time, CA/latency/data/recovery.
module hyperbus_txn_ctrl
  import hyperbus_pkg::*;
#(
  parameter int unsigned NR_CS      = 2,
  parameter int unsigned LATENCY    = 6,
  parameter int unsigned RWR        = DEFAULT_RWR,
  parameter int unsigned RD_TIMEOUT = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     trans_valid_i,
  output logic                     trans_ready_o,
  input  logic                     trans_write_i,
  input  logic [31:0]              trans_addr_i,
  input  logic [$clog2(NR_CS)-1:0] trans_cs_i,
  input  logic [15:0]              trans_len_i,
  input  logic                     wdata_valid_i,
  output logic                     wdata_ready_o,
  input  logic [15:0]              wdata_i,
  output logic                     rdata_valid_o,
  output logic [15:0]              rdata_o,
  output logic                     done_o,
  output logic                     error_o,
  output logic [NR_CS-1:0]         phy_cs_no,
  output logic                     phy_ck_en_o,
  output logic [15:0]              phy_dq_o,
  output logic                     phy_dq_oe_o,
  output logic [1:0]               phy_rwds_o,
  output logic                     phy_rwds_oe_o,
  input  logic                     phy_rwds_i,
  input  logic                     phy_rdata_valid_i,
  input  logic [15:0]              phy_rdata_i
);

  state_e                   state, state_d;
  logic [15:0]              cnt, cnt_d;
  logic [15:0]              tcnt, tcnt_d;
  logic                     armed;
  logic                     wr_q;
  logic [31:0]              addr_q;
  logic [$clog2(NR_CS)-1:0] cs_q;
  logic [15:0]              len_q;
  logic                     lat2_q;
  logic                     accept;
  ca_t                      ca;
  logic [15:0]              lat_last;
  logic [NR_CS-1:0]         cs_sel;

  assign ca       = ca_pack(wr_q, addr_q);
  assign lat_last = lat2_q ? 16'(2 * LATENCY - 1) : 16'(LATENCY - 1);
  assign cs_sel   = ~(NR_CS'(1) << cs_q);
  assign accept   = (state == ST_IDLE) && armed && trans_valid_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
      cnt   <= '0;
      tcnt  <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
      tcnt  <= tcnt_d;
    end
  end

  // armed holds off trans_ready_o until the first edge after reset release
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      armed         <= 1'b0;
      wr_q          <= 1'b0;
      addr_q        <= '0;
      cs_q          <= '0;
      len_q         <= '0;
      lat2_q        <= 1'b0;
      rdata_valid_o <= 1'b0;
      rdata_o       <= '0;
    end else begin
      armed <= 1'b1;
      if (accept) begin
        wr_q   <= trans_write_i;
        addr_q <= trans_addr_i;
        cs_q   <= trans_cs_i;
        len_q  <= trans_len_i;
      end
      if (state == ST_CMD && cnt == 16'd0) begin
        lat2_q <= phy_rwds_i;
      end
      rdata_valid_o <= (state == ST_RDATA) && phy_rdata_valid_i;
      if ((state == ST_RDATA) && phy_rdata_valid_i) begin
        rdata_o <= phy_rdata_i;
      end
    end
  end

  always_comb begin
    state_d       = state;
    cnt_d         = cnt;
    tcnt_d        = tcnt;
    trans_ready_o = 1'b0;
    wdata_ready_o = 1'b0;
    done_o        = 1'b0;
    error_o       = 1'b0;
    phy_cs_no     = '1;
    phy_ck_en_o   = 1'b0;
    phy_dq_o      = '0;
    phy_dq_oe_o   = 1'b0;
    phy_rwds_o    = 2'b00;
    phy_rwds_oe_o = 1'b0;
    case (state)
      ST_IDLE: begin
        trans_ready_o = armed;
        if (accept) begin
          state_d = ST_CS_SETUP;
        end
      end
      ST_CS_SETUP: begin
        phy_cs_no = cs_sel;
        cnt_d     = '0;
        state_d   = ST_CMD;
      end
      ST_CMD: begin
        phy_cs_no   = cs_sel;
        phy_ck_en_o = 1'b1;
        phy_dq_oe_o = 1'b1;
        case (cnt[1:0])
          2'd0:    phy_dq_o = ca[47:32];
          2'd1:    phy_dq_o = ca[31:16];
          default: phy_dq_o = ca[15:0];
        endcase
        if (cnt == 16'd2) begin
          cnt_d   = '0;
          state_d = ST_LATENCY;
        end else begin
          cnt_d = cnt + 16'd1;
        end
      end
      ST_LATENCY: begin
        phy_cs_no   = cs_sel;
        phy_ck_en_o = 1'b1;
        if (cnt == lat_last) begin
          cnt_d   = '0;
          tcnt_d  = '0;
          state_d = wr_q ? ST_WDATA : ST_RDATA;
        end else begin
          cnt_d = cnt + 16'd1;
        end
      end
      ST_WDATA: begin
        phy_cs_no     = cs_sel;
        wdata_ready_o = 1'b1;
        phy_dq_oe_o   = 1'b1;
        phy_rwds_oe_o = 1'b1;
        phy_dq_o      = wdata_i;
        phy_ck_en_o   = wdata_valid_i;
        if (wdata_valid_i) begin
          cnt_d = cnt + 16'd1;
          if (cnt == len_q) begin
            state_d = ST_CS_HOLD;
          end
        end
      end
      ST_RDATA: begin
        phy_cs_no   = cs_sel;
        phy_ck_en_o = 1'b1;
        if (phy_rdata_valid_i) begin
          tcnt_d = '0;
          cnt_d  = cnt + 16'd1;
          if (cnt == len_q) begin
            state_d = ST_CS_HOLD;
          end
        end else if (tcnt == 16'(RD_TIMEOUT - 1)) begin
          error_o = 1'b1;
          state_d = ST_CS_HOLD;
        end else begin
          tcnt_d = tcnt + 16'd1;
        end
      end
      ST_CS_HOLD: begin
        phy_cs_no = cs_sel;
        cnt_d     = '0;
        state_d   = ST_RECOVERY;
      end
      ST_RECOVERY: begin
        done_o = (cnt == 16'd0);
        if (cnt == 16'(RWR - 1)) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_hyperbus_txn_ctrl.sv
// Directed bench for hyperbus_txn_ctrl with a cycle-plan reference model.
module tb_hyperbus_txn_ctrl;

  localparam int N    = 512;
  localparam int LAT  = 6;
  localparam int RWR  = 4;
  localparam int RDTO = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        trans_valid, trans_ready, trans_write;
  logic [31:0] trans_addr;
  logic        trans_cs;
  logic [15:0] trans_len;
  logic        wdata_valid, wdata_ready;
  logic [15:0] wdata;
  logic        rdata_valid;
  logic [15:0] rdata;
  logic        done, error;
  logic [1:0]  phy_cs_n;
  logic        phy_ck_en;
  logic [15:0] phy_dq;
  logic        phy_dq_oe;
  logic [1:0]  phy_rwds;
  logic        phy_rwds_oe;
  logic        phy_rwds_in, phy_rdata_valid;
  logic [15:0] phy_rdata;

  hyperbus_txn_ctrl #(
    .NR_CS(2), .LATENCY(LAT), .RWR(RWR), .RD_TIMEOUT(RDTO)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .trans_valid_i(trans_valid), .trans_ready_o(trans_ready),
    .trans_write_i(trans_write), .trans_addr_i(trans_addr),
    .trans_cs_i(trans_cs), .trans_len_i(trans_len),
    .wdata_valid_i(wdata_valid), .wdata_ready_o(wdata_ready), .wdata_i(wdata),
    .rdata_valid_o(rdata_valid), .rdata_o(rdata),
    .done_o(done), .error_o(error),
    .phy_cs_no(phy_cs_n), .phy_ck_en_o(phy_ck_en),
    .phy_dq_o(phy_dq), .phy_dq_oe_o(phy_dq_oe),
    .phy_rwds_o(phy_rwds), .phy_rwds_oe_o(phy_rwds_oe),
    .phy_rwds_i(phy_rwds_in), .phy_rdata_valid_i(phy_rdata_valid),
    .phy_rdata_i(phy_rdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst, tv, tw;
    logic [31:0] ta;
    logic        tcs;
    logic [15:0] tl;
    logic        wv;
    logic [15:0] wd;
    logic        rwds, prv;
    logic [15:0] prd;
  } stim_t;

  typedef struct packed {
    logic [1:0]  cs;
    logic        ck, dqoe;
    logic [15:0] dq;
    logic        dqchk, rwdsoe, rdy, wrdy, done, err, rv;
    logic [15:0] rd;
    logic        rstchk;
  } exp_t;

  stim_t stim [N];
  exp_t  ex   [N];
  int    cyc = 0;
  int    ncyc;
  int    n_vec = 0;
  int    n_err = 0;
  int    p_ca1 = -1, p_ca2 = -1, p_d1 = -1, p_total = -1, p_to = -1, p_gap = -1;
  int    acc_cyc = -1000, done_cyc = -1000, cmd_cyc = -1000;
  int    err_cyc = -1000, beat_cyc = -1000;
  logic  prev_ck = 1'b0, prev_dqoe = 1'b0;

  function automatic logic [15:0] ca_word(input logic w, input logic [31:0] addr, input int k);
    logic [47:0] ca;
    ca = {~w, 1'b0, 1'b1, addr[31:3], 13'd0, addr[2:0]};
    case (k)
      0:       return ca[47:32];
      1:       return ca[31:16];
      default: return ca[15:0];
    endcase
  endfunction

  task automatic busy(input int t, input logic cs, input logic ck);
    ex[t].cs  = ~(2'b01 << cs);
    ex[t].rdy = 1'b0;
    ex[t].ck  = ck;
  endtask

  task automatic plan_head(input int a, input logic w, input logic [31:0] addr, input logic cs,
                           input logic [15:0] len, input logic rwds, input int early);
    for (int k = 0; k <= early; k++) begin
      stim[a-k].tv  = 1'b1;
      stim[a-k].tw  = w;
      stim[a-k].ta  = addr;
      stim[a-k].tcs = cs;
      stim[a-k].tl  = len;
    end
    busy(a + 1, cs, 1'b0);
    for (int k = 0; k < 3; k++) begin
      busy(a + 2 + k, cs, 1'b1);
      ex[a+2+k].dqoe   = 1'b1;
      ex[a+2+k].dq     = ca_word(w, addr, k);
      ex[a+2+k].dqchk  = 1'b1;
      stim[a+2+k].rwds = rwds;
    end
  endtask

  task automatic plan(input int a, input logic w, input logic [31:0] addr, input logic cs,
                      input logic [15:0] len, input logic rwds, input int early,
                      input int stall_at, input int stall_n, input int nret,
                      input logic [15:0] seed, output int idle_at);
    int lat, t, h, last, e;
    plan_head(a, w, addr, cs, len, rwds, early);
    lat = rwds ? 2 * LAT : LAT;
    for (int k = 0; k < lat; k++) busy(a + 5 + k, cs, 1'b1);
    t = a + 5 + lat;
    if (w) begin
      for (int i = 0; i <= int'(len); i++) begin
        if (i == stall_at) begin
          for (int s = 0; s < stall_n; s++) begin
            busy(t, cs, 1'b0);
            ex[t].dqoe = 1'b1; ex[t].rwdsoe = 1'b1; ex[t].wrdy = 1'b1;
            t++;
          end
        end
        busy(t, cs, 1'b1);
        ex[t].dqoe = 1'b1; ex[t].rwdsoe = 1'b1; ex[t].wrdy = 1'b1;
        ex[t].dq = seed + 16'(i); ex[t].dqchk = 1'b1;
        stim[t].wv = 1'b1; stim[t].wd = seed + 16'(i);
        t++;
      end
      h = t;
    end else begin
      last = t + 2 * (nret - 1);
      for (int i = 0; i < nret; i++) begin
        stim[t+2*i].prv  = 1'b1;
        stim[t+2*i].prd  = seed + 16'(i);
        ex[t+2*i+1].rv   = 1'b1;
        ex[t+2*i+1].rd   = seed + 16'(i);
      end
      if (nret == int'(len) + 1) begin
        h = last + 1;
      end else begin
        e = last + RDTO;
        ex[e].err = 1'b1;
        h = e + 1;
      end
      for (int k = t; k < h; k++) busy(k, cs, 1'b1);
    end
    busy(h, cs, 1'b0);
    for (int k = 0; k < RWR; k++) ex[h+1+k].rdy = 1'b0;
    ex[h+1].done = 1'b1;
    idle_at = h + 1 + RWR;
  endtask

  task automatic plan_abort(input int a, output int idle_at);
    plan_head(a, 1'b1, 32'h0000_0080, 1'b1, 16'd3, 1'b0, 0);
    busy(a + 5, 1'b1, 1'b1);
    for (int k = 6; k <= 7; k++) stim[a+k].rst = 1'b1;
    for (int k = 6; k <= 8; k++) begin
      ex[a+k].rdy = 1'b0;
      ex[a+k].rstchk = 1'b1;
    end
    idle_at = a + 9;
  endtask

  task automatic apply(input int c);
    rst             = stim[c].rst;
    trans_valid     = stim[c].tv;
    trans_write     = stim[c].tw;
    trans_addr      = stim[c].ta;
    trans_cs        = stim[c].tcs;
    trans_len       = stim[c].tl;
    wdata_valid     = stim[c].wv;
    wdata           = stim[c].wd;
    phy_rwds_in     = stim[c].rwds;
    phy_rdata_valid = stim[c].prv;
    phy_rdata       = stim[c].prd;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, want);
    end
  endtask

  task automatic compare(input int c);
    exp_t e;
    e = ex[c];
    chk("cs_n",    32'(phy_cs_n),    32'(e.cs));
    chk("ck_en",   32'(phy_ck_en),   32'(e.ck));
    chk("dq_oe",   32'(phy_dq_oe),   32'(e.dqoe));
    if (e.dqchk) chk("dq", 32'(phy_dq), 32'(e.dq));
    chk("rwds_oe", 32'(phy_rwds_oe), 32'(e.rwdsoe));
    chk("rwds",    32'(phy_rwds),    32'd0);
    chk("ready",   32'(trans_ready), 32'(e.rdy));
    chk("wready",  32'(wdata_ready), 32'(e.wrdy));
    chk("done",    32'(done),        32'(e.done));
    chk("error",   32'(error),       32'(e.err));
    chk("rvalid",  32'(rdata_valid), 32'(e.rv));
    if (e.rv) chk("rdata", 32'(rdata), 32'(e.rd));
    if (e.rstchk) begin
      chk("dq_rst",    32'(phy_dq), 32'd0);
      chk("rdata_rst", 32'(rdata),  32'd0);
    end
  endtask

  always @(negedge clk) begin
    if (cyc > 0 && cyc < N) begin
      if (trans_valid && trans_ready) acc_cyc = cyc;
      if (done) done_cyc = cyc;
      if (error) err_cyc = cyc;
      if (phy_rdata_valid) beat_cyc = cyc;
      if (phy_dq_oe && !prev_dqoe && !prev_ck) cmd_cyc = cyc;
      prev_ck   = phy_ck_en;
      prev_dqoe = phy_dq_oe;
      compare(cyc);
      if (cyc == p_ca1)     chk("ca_hi_wr_lit", 32'(phy_dq), 32'h2000);
      if (cyc == p_ca1 + 1) chk("ca_mid_wr_lit", 32'(phy_dq), 32'h0002);
      if (cyc == p_ca1 + 2) chk("ca_lo_wr_lit", 32'(phy_dq), 32'h0000);
      if (cyc == p_ca2)     chk("ca_hi_rd_lit", 32'(phy_dq), 32'hA000);
      if (cyc == p_d1)      chk("first_wbeat_lit", 32'(phy_dq), 32'h1100);
      if (cyc == p_total)   chk("accept_to_done_lit", 32'(done_cyc - acc_cyc), 32'd16);
      if (cyc == p_to)      chk("timeout_gap_lit", 32'(err_cyc - beat_cyc), 32'd64);
      if (cyc == p_gap)     chk("rwr_gap_lit", 32'(cmd_cyc - done_cyc), 32'd6);
    end
  end

  initial begin
    int a, nxt;
    for (int i = 0; i < N; i++) begin
      stim[i]    = '0;
      ex[i]      = '0;
      ex[i].cs   = 2'b11;
      ex[i].rdy  = 1'b1;
    end
    for (int i = 0; i <= 2; i++) stim[i].rst = 1'b1;
    for (int i = 0; i <= 3; i++) begin
      ex[i].rdy    = 1'b0;
      ex[i].rstchk = 1'b1;
    end

    a = 6;
    p_ca1 = a + 2;
    p_d1  = a + 11;
    plan(a, 1'b1, 32'h0000_0010, 1'b0, 16'd3, 1'b0, 0, -1, 0, 0, 16'h1100, nxt);
    p_total = nxt;
    a = nxt + 2;
    p_ca2 = a + 2;
    plan(a, 1'b0, 32'h0000_0000, 1'b1, 16'd1, 1'b1, 0, -1, 0, 2, 16'hC000, nxt);
    a = nxt;
    plan(a, 1'b1, 32'h1234_5678, 1'b0, 16'd5, 1'b0, 3, 2, 3, 0, 16'h5A00, nxt);
    a = nxt + 2;
    plan(a, 1'b0, 32'h0000_0100, 1'b1, 16'd3, 1'b0, 0, -1, 0, 1, 16'hBEE0, nxt);
    p_to = nxt;
    a = nxt + 2;
    plan(a, 1'b1, 32'h0000_0040, 1'b0, 16'd0, 1'b0, 0, -1, 0, 0, 16'h7700, nxt);
    a = nxt;
    p_gap = a + 2;
    plan(a, 1'b0, 32'h0000_0048, 1'b1, 16'd0, 1'b0, 4, -1, 0, 1, 16'hD000, nxt);
    a = nxt + 2;
    plan_abort(a, nxt);
    a = nxt + 1;
    plan(a, 1'b1, 32'h2000_0003, 1'b1, 16'd1, 1'b0, 0, -1, 0, 0, 16'h3300, nxt);
    ncyc = nxt + 4;

    cyc = 0;
    apply(0);
    for (int c = 1; c < ncyc; c++) begin
      @(posedge clk);
      #1;
      cyc = c;
      apply(c);
    end
    @(posedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
